// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline encodings: hazard FSM states and ALU operand forward selects.
package hazard_fwd_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_STALL = 2'b01,
    HZ_FLUSH = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: reset wins, then increment unless already saturated
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detection, operand forwarding, hazard state tracking and
// saturating stall/flush performance counters.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic [4:0]       EX_Rs,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             M_RegWrite,
  input  logic [4:0]       M_WriteReg,
  input  logic             M_BranchCon,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [1:0]       HzState,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic      load_use_s;
  logic      stall_inc_s;
  logic      pc_write_s;
  logic      ifid_write_s;
  logic      idex_bubble_s;
  logic      flush_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  hz_state_e state_r;
  hz_state_e state_next_s;

  assign load_use_s = EX_MemRead && (EX_WriteReg != 5'd0) &&
                      ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));

  // A taken branch squashes the stalled instruction anyway, so it overrides load-use
  assign stall_inc_s = load_use_s && !M_BranchCon;

  // Stall / flush control derived only from current-cycle inputs
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    idex_bubble_s = 1'b0;
    flush_s       = 1'b0;
    if (M_BranchCon) begin
      flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_bubble_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a_s = FWD_RF;
    fwd_b_s = FWD_RF;
    if (M_RegWrite && (M_WriteReg != 5'd0) && (M_WriteReg == EX_Rs)) begin
      fwd_a_s = FWD_MEM;
    end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == EX_Rs)) begin
      fwd_a_s = FWD_WB;
    end else begin
      fwd_a_s = FWD_RF;
    end
    if (M_RegWrite && (M_WriteReg != 5'd0) && (M_WriteReg == EX_Rt)) begin
      fwd_b_s = FWD_MEM;
    end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == EX_Rt)) begin
      fwd_b_s = FWD_WB;
    end else begin
      fwd_b_s = FWD_RF;
    end
  end

  // Next hazard state is independent of the current state
  always_comb begin
    state_next_s = HZ_RUN;
    if (M_BranchCon) begin
      state_next_s = HZ_FLUSH;
    end else if (load_use_s) begin
      state_next_s = HZ_STALL;
    end else begin
      state_next_s = HZ_RUN;
    end
  end

  // Hazard state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= HZ_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .reset (Reset),
    .inc   (stall_inc_s),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .reset (Reset),
    .inc   (M_BranchCon),
    .count (FlushCnt)
  );

  assign PCWrite    = pc_write_s;
  assign IFIDWrite  = ifid_write_s;
  assign IDEXBubble = idex_bubble_s;
  assign IFIDFlush  = flush_s;
  assign IDEXFlush  = flush_s;
  assign EXMEMFlush = flush_s;
  assign ForwardA   = fwd_a_s;
  assign ForwardB   = fwd_b_s;
  assign HzState    = state_r;

endmodule
